// File: rtl/apu_stereo_mixer_n_if.sv
// Bus between the per-channel generators / output formatter and the stereo mixer.
// The producer side drives the master modport; the mixer uses the slave modport.
interface apu_stereo_mixer_n_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 24,
  parameter int VOL_W    = 3
);
  logic                         sample_strobe;
  logic [NUM_CH*SAMPLE_W-1:0]   channel_samples;
  logic [NUM_CH-1:0]            pause_channels;
  logic [NUM_CH-1:0]            pan_left;
  logic [NUM_CH-1:0]            pan_right;
  logic                         master_enable;
  logic [VOL_W-1:0]             vol_left;
  logic [VOL_W-1:0]             vol_right;
  logic                         busy;
  logic                         overrun;
  logic                         output_valid;
  logic signed [SAMPLE_W-1:0]   output_wave_left;
  logic signed [SAMPLE_W-1:0]   output_wave_right;

  modport master (
    output sample_strobe, channel_samples, pause_channels, pan_left, pan_right,
           master_enable, vol_left, vol_right,
    input  busy, overrun, output_valid, output_wave_left, output_wave_right
  );

  modport slave (
    input  sample_strobe, channel_samples, pause_channels, pan_left, pan_right,
           master_enable, vol_left, vol_right,
    output busy, overrun, output_valid, output_wave_left, output_wave_right
  );
endinterface

// File: rtl/apu_stereo_mixer_n.sv
// Time-multiplexed NUM_CH-channel stereo mixer: one channel accumulated per cycle,
// then a master-volume multiply with signed saturation per side.
module apu_stereo_mixer_n #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 24,
  parameter int VOL_W    = 3
) (
  input logic                system_clock,
  input logic                reset,
  apu_stereo_mixer_n_if.slave mix
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int PW    = ACC_W + VOL_W + 1;
  localparam logic signed [PW-1:0] SMAX = PW'((longint'(1) <<< (SAMPLE_W - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, LOAD} state_t;

  state_t                      state_q;
  logic signed [SAMPLE_W-1:0]  smp_q [NUM_CH];
  logic [NUM_CH-1:0]           pause_q, panl_q, panr_q;
  logic                        en_q;
  logic [VOL_W-1:0]            voll_q, volr_q;
  logic signed [ACC_W-1:0]     acc_l_q, acc_r_q;
  logic [IDX_W-1:0]            idx_q;
  logic signed [SAMPLE_W-1:0]  out_l_q, out_r_q;
  logic                        busy_q, overrun_q, valid_q;

  // Floor-rounded gain of (vol+1)/2^VOL_W, clamped to the sample range.
  function automatic logic signed [SAMPLE_W-1:0] scale_sat(
    input logic signed [ACC_W-1:0] acc,
    input logic [VOL_W-1:0]        vol
  );
    logic signed [PW-1:0] gain, prod, shr;
    gain = PW'({1'b0, vol}) + PW'(1);
    prod = PW'(acc) * gain;
    shr  = prod >>> VOL_W;
    if (shr > SMAX)      return SMAX[SAMPLE_W-1:0];
    else if (shr < SMIN) return SMIN[SAMPLE_W-1:0];
    else                 return shr[SAMPLE_W-1:0];
  endfunction

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      for (int k = 0; k < NUM_CH; k++) smp_q[k] <= '0;
      pause_q   <= '0;
      panl_q    <= '0;
      panr_q    <= '0;
      en_q      <= 1'b0;
      voll_q    <= '0;
      volr_q    <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      idx_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= mix.sample_strobe && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (mix.sample_strobe) begin
            for (int k = 0; k < NUM_CH; k++)
              smp_q[k] <= mix.channel_samples[k*SAMPLE_W +: SAMPLE_W];
            pause_q <= mix.pause_channels;
            panl_q  <= mix.pan_left;
            panr_q  <= mix.pan_right;
            en_q    <= mix.master_enable;
            voll_q  <= mix.vol_left;
            volr_q  <= mix.vol_right;
            acc_l_q <= '0;
            acc_r_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (panl_q[idx_q] && !pause_q[idx_q]) acc_l_q <= acc_l_q + ACC_W'(smp_q[idx_q]);
          if (panr_q[idx_q] && !pause_q[idx_q]) acc_r_q <= acc_r_q + ACC_W'(smp_q[idx_q]);
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_CH - 1)) state_q <= SCALE;
        end
        SCALE: begin
          // Results land on the edge into LOAD so they are visible, with the valid pulse, during LOAD.
          out_l_q <= en_q ? scale_sat(acc_l_q, voll_q) : '0;
          out_r_q <= en_q ? scale_sat(acc_r_q, volr_q) : '0;
          valid_q <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mix.busy              = busy_q;
  assign mix.overrun           = overrun_q;
  assign mix.output_valid      = valid_q;
  assign mix.output_wave_left  = out_l_q;
  assign mix.output_wave_right = out_r_q;
endmodule

// File: tb/tb_apu_stereo_mixer_n.sv
// Scoreboard bench for apu_stereo_mixer_n: directed and random mixes against a
// plain-arithmetic reference model, plus timing, overrun and reset behaviour.
module tb_apu_stereo_mixer_n;
  localparam int NC = 4;
  localparam int SW = 24;
  localparam int VW = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   valid_cnt;
  logic [SW-1:0] exp_l_q[$];
  logic [SW-1:0] exp_r_q[$];

  apu_stereo_mixer_n_if #(.NUM_CH(NC), .SAMPLE_W(SW), .VOL_W(VW)) bus ();

  apu_stereo_mixer_n #(.NUM_CH(NC), .SAMPLE_W(SW), .VOL_W(VW)) dut (
    .system_clock (clk),
    .reset        (rst_n),
    .mix          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum routed, unpaused channels; multiply by (vol+1); floor-divide by 2^VW; clamp.
  function automatic logic [SW-1:0] model(input logic [NC*SW-1:0] s, input logic [NC-1:0] pa,
                                          input logic [NC-1:0] pn, input logic en,
                                          input logic [VW-1:0] vol);
    longint sum, p, q, lim;
    logic [63:0] r;
    sum = 0;
    if (!en) return '0;
    for (int k = 0; k < NC; k++)
      if (pn[k] && !pa[k]) sum += longint'($signed(s[k*SW +: SW]));
    p = sum * (longint'(vol) + 1);
    q = p / (longint'(1) << VW);
    if (p < 0 && (p % (longint'(1) << VW)) != 0) q = q - 1;
    lim = longint'(1) << (SW - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
    r = q;
    return r[SW-1:0];
  endfunction

  function automatic logic [NC*SW-1:0] rep(input logic [SW-1:0] v);
    return {NC{v}};
  endfunction

  function automatic logic [NC*SW-1:0] rand_bus();
    logic [NC*SW-1:0] b;
    for (int k = 0; k < NC; k++) b[k*SW +: SW] = SW'($urandom);
    return b;
  endfunction

  task automatic scramble();
    bus.channel_samples = rand_bus();
    bus.pause_channels  = NC'($urandom);
    bus.pan_left        = NC'($urandom);
    bus.pan_right       = NC'($urandom);
    bus.master_enable   = 1'($urandom);
    bus.vol_left        = VW'($urandom);
    bus.vol_right       = VW'($urandom);
  endtask

  task automatic drive(input logic [NC*SW-1:0] s, input logic [NC-1:0] pa, input logic [NC-1:0] pl,
                       input logic [NC-1:0] pr, input logic en,
                       input logic [VW-1:0] vl, input logic [VW-1:0] vr);
    bus.channel_samples = s;
    bus.pause_channels  = pa;
    bus.pan_left        = pl;
    bus.pan_right       = pr;
    bus.master_enable   = en;
    bus.vol_left        = vl;
    bus.vol_right       = vr;
  endtask

  // One full mix: strobe, scramble inputs afterwards, check busy and valid latency, then hold.
  task automatic do_mix(input logic [NC*SW-1:0] s, input logic [NC-1:0] pa, input logic [NC-1:0] pl,
                        input logic [NC-1:0] pr, input logic en,
                        input logic [VW-1:0] vl, input logic [VW-1:0] vr);
    int c;
    bit seen;
    logic [SW-1:0] el, er;
    @(negedge clk);
    drive(s, pa, pl, pr, en, vl, vr);
    el = model(s, pa, pl, en, vl);
    er = model(s, pa, pr, en, vr);
    exp_l_q.push_back(el);
    exp_r_q.push_back(er);
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    scramble();
    c = 1;
    seen = 1'b0;
    while (c <= NC + 6 && !seen) begin
      if (bus.output_valid) seen = 1'b1;
      else begin
        chk("busy_during_mix", bus.busy, 1);
        @(negedge clk);
        c++;
      end
    end
    chk("valid_latency", seen ? c : 0, NC + 2);
    @(negedge clk);
    chk("busy_after_mix", bus.busy, 0);
    chk("valid_single_cycle", bus.output_valid, 0);
    repeat (2) @(negedge clk);
    chk("hold_left", $unsigned(bus.output_wave_left), el);
    chk("hold_right", $unsigned(bus.output_wave_right), er);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.output_valid) begin
      valid_cnt++;
      if (exp_l_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("left", $unsigned(bus.output_wave_left), exp_l_q.pop_front());
        chk("right", $unsigned(bus.output_wave_right), exp_r_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NC*SW-1:0] s;
    logic [SW-1:0] ea;
    int v0;
    vectors = 0;
    miscompares = 0;
    valid_cnt = 0;
    rst_n = 1'b0;
    bus.sample_strobe = 1'b0;
    drive('0, '0, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset_left", $unsigned(bus.output_wave_left), 0);
    chk("reset_right", $unsigned(bus.output_wave_right), 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_valid", bus.output_valid, 0);
    chk("reset_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_mix(rep(24'h100000), 4'h0, 4'hF, 4'hF, 1'b1, 3'd7, 3'd7);
    do_mix(rep(24'h600000), 4'h0, 4'hF, 4'h0, 1'b1, 3'd7, 3'd7);
    do_mix(rep(24'hA00000), 4'h0, 4'hF, 4'h0, 1'b1, 3'd7, 3'd7);
    do_mix({24'h0, 24'h0, 24'h0, 24'h080000}, 4'h0, 4'hF, 4'hF, 1'b1, 3'd3, 3'd0);
    do_mix({24'h0, 24'h0, 24'h0, 24'hFFFFFF}, 4'h0, 4'hF, 4'hF, 1'b1, 3'd0, 3'd0);
    do_mix({24'h000080, 24'h000040, 24'h000020, 24'h000010}, 4'b0010, 4'b0011, 4'b1100,
           1'b1, 3'd7, 3'd7);
    do_mix(rep(24'h123456), 4'h0, 4'hF, 4'hF, 1'b0, 3'd7, 3'd7);
    do_mix(rep(24'h123456), 4'h0, 4'h0, 4'h0, 1'b1, 3'd7, 3'd7);
    do_mix(rep(24'h123456), 4'hF, 4'hF, 4'hF, 1'b1, 3'd7, 3'd7);

    // Strobes during ACCUM (cycle 3) and during LOAD are both dropped with an overrun pulse.
    s = rep(24'h010203);
    ea = model(s, 4'h0, 4'hF, 1'b1, 3'd5);
    @(negedge clk);
    drive(s, 4'h0, 4'hF, 4'hF, 1'b1, 3'd5, 3'd5);
    exp_l_q.push_back(ea);
    exp_r_q.push_back(ea);
    v0 = valid_cnt;
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    scramble();
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    chk("overrun_accum", bus.overrun, 1);
    @(negedge clk);
    chk("overrun_one_cycle", bus.overrun, 0);
    @(negedge clk);
    chk("valid_with_overrun", bus.output_valid, 1);
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    chk("overrun_load", bus.overrun, 1);
    chk("load_strobe_dropped", bus.busy, 0);
    repeat (NC + 6) @(negedge clk);
    chk("single_valid_pulse", valid_cnt - v0, 1);

    // Reset in the middle of ACCUM abandons the mix.
    do_mix(rep(24'h100000), 4'h0, 4'hF, 4'hF, 1'b1, 3'd7, 3'd7);
    @(negedge clk);
    drive(rep(24'h200000), 4'h0, 4'hF, 4'hF, 1'b1, 3'd7, 3'd7);
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_left", $unsigned(bus.output_wave_left), 0);
    chk("midreset_right", $unsigned(bus.output_wave_right), 0);
    chk("midreset_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (NC + 6) @(negedge clk);
    chk("no_valid_after_reset", valid_cnt - v0, 0);
    chk("outputs_zero_after_reset", $unsigned(bus.output_wave_left), 0);

    for (int i = 0; i < 25; i++) begin
      s = rand_bus();
      if (i % 3 == 0) s = rep(SW'($urandom) | 24'h400000);
      do_mix(s, NC'($urandom), NC'($urandom), NC'($urandom), ($urandom % 5) != 0,
             VW'($urandom), VW'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_l_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apu_stereo_mixer_n.md
Name: apu_stereo_mixer_n

Overview:
Parametrised, time-multiplexed stereo mixer for the audio path. It replaces the fixed 4-channel combinational mixer with an NUM_CH-channel sequential datapath that applies per-channel left/right routing and pause gating, then scales each side by a true master-volume multiply with signed saturation. It sits between the per-channel generators and the DAC/output formatter and produces one registered stereo sample per sample_strobe.

Parameters:
NUM_CH, 4, number of input channels (≥1)
SAMPLE_W, 24, signed two's-complement width of each channel sample and of each output
VOL_W, 3, master volume field width; gain = (vol+1)/2^VOL_W

Ports:
system_clock  input  1  single clock domain
reset  input  1  asynchronous, active-low reset
sample_strobe  input  1  one-cycle request to mix the current inputs
channel_samples  input  NUM_CH*SAMPLE_W  channel k in bits [k*SAMPLE_W +: SAMPLE_W], signed
pause_channels  input  NUM_CH  1 = channel k contributes 0 to both sides
pan_left  input  NUM_CH  1 = channel k routed to left
pan_right  input  NUM_CH  1 = channel k routed to right
master_enable  input  1  0 = outputs forced to zero (sound off)
vol_left  input  VOL_W  left master volume
vol_right  input  VOL_W  right master volume
busy  output  1  high while a mix is in progress
overrun  output  1  one-cycle pulse when a strobe arrives while busy
output_valid  output  1  one-cycle pulse when new outputs are loaded
output_wave_left  output  SAMPLE_W  signed, registered
output_wave_right  output  SAMPLE_W  signed, registered

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, overrun=0, output_valid=0, both outputs=0, accumulators and index=0.
- ACC_W = SAMPLE_W + clog2(NUM_CH) (minimum SAMPLE_W+1); accumulators are signed ACC_W and cannot overflow.
- States: IDLE, ACCUM, SCALE, LOAD.
- IDLE: on sample_strobe, snapshot all inputs into holding registers, clear the accumulators, set index=0, then go to ACCUM. Later input changes do not affect this mix.
- ACCUM: one channel per cycle. Sign-extend channel[index] and add it to acc_l if pan_left[index]&&!pause[index], and to acc_r if pan_right[index]&&!pause[index]. Increment index. After index NUM_CH-1, go to SCALE.
- SCALE: prod = acc × (vol+1) as a signed value ACC_W+VOL_W+1 bits wide, then arithmetic shift right by VOL_W (floor rounding toward −inf). Saturate to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1]. Register the result. Go to LOAD.
- LOAD: load the outputs with the saturated values, or with 0 if the snapshotted master_enable=0. Pulse output_valid for one cycle. Return to IDLE.
- Latency: strobe sampled at edge 0 → output_valid high in cycle NUM_CH+2. Outputs change only in that cycle and hold between mixes.
- busy=1 in ACCUM, SCALE and LOAD. A strobe in any non-IDLE state is dropped and overrun pulses in the following cycle. A strobe in the same cycle that LOAD returns to IDLE is also dropped, because the state is not yet IDLE.
- Reset mid-mix: the mix is abandoned, no output_valid pulse, and outputs return to 0.
- With every pan bit off or every channel paused, a mix still completes and loads 0.

Test Plan:
- Reset → outputs 0x000000, busy=0, output_valid=0; assert reset during ACCUM → no valid pulse, outputs stay 0.
- NUM_CH=4, all channels 0x100000, all pans on, vol 7/7, enable=1, strobe → valid exactly at cycle 6, left=right=0x400000, busy high in cycles 1–5.
- Saturation: all channels 0x600000, left only → left=0x7FFFFF, right=0x000000; all channels 0xA00000 → left=0x800000.
- Volume/rounding: ch0=0x080000 both sides, others 0, vol_left=3, vol_right=0 → left=0x040000, right=0x010000; ch0=0xFFFFFF, vol 0 → 0xFFFFFF.
- Routing/pause: ch0..3 = 0x000010, 0x000020, 0x000040, 0x000080; pan_left=0b0011, pan_right=0b1100, pause=0b0010, vol 7 → left=0x000010, right=0x0000C0.
- Strobe at cycle 3 of a mix → overrun pulse, single valid pulse with the first mix's values; master_enable=0 → valid pulse with outputs 0x000000.
